// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and the 78-bit TLB entry layout.
package cp0_pkg;

  localparam logic [4:0] REG_INDEX    = 5'd0;
  localparam logic [4:0] REG_RANDOM   = 5'd1;
  localparam logic [4:0] REG_ENTRYLO0 = 5'd2;
  localparam logic [4:0] REG_ENTRYLO1 = 5'd3;
  localparam logic [4:0] REG_CONTEXT  = 5'd4;
  localparam logic [4:0] REG_PAGEMASK = 5'd5;
  localparam logic [4:0] REG_WIRED    = 5'd6;
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_ENTRYHI  = 5'd10;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // {VPN2,ASID,G,PFN0,C0,D0,V0,PFN1,C1,D1,V1}, LSB offsets
  localparam int unsigned TLB_ENTRY_W  = 78;
  localparam int unsigned TLB_V1_LSB   = 0;
  localparam int unsigned TLB_D1_LSB   = 1;
  localparam int unsigned TLB_C1_LSB   = 2;
  localparam int unsigned TLB_PFN1_LSB = 5;
  localparam int unsigned TLB_V0_LSB   = 25;
  localparam int unsigned TLB_D0_LSB   = 26;
  localparam int unsigned TLB_C0_LSB   = 27;
  localparam int unsigned TLB_PFN0_LSB = 30;
  localparam int unsigned TLB_G_LSB    = 50;
  localparam int unsigned TLB_ASID_LSB = 51;
  localparam int unsigned TLB_VPN2_LSB = 59;

  localparam int unsigned TLB_PFN_W  = 20;
  localparam int unsigned TLB_C_W    = 3;
  localparam int unsigned TLB_ASID_W = 8;
  localparam int unsigned TLB_VPN2_W = 19;
  // {PFN,C,D,V} of one page half, contiguous in the entry
  localparam int unsigned TLB_LO_W   = TLB_PFN_W + TLB_C_W + 2;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with a power-of-two prescaler and sticky timer-interrupt flag.
module cp0_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cnt_wen,
  input  logic        cmp_wen,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  logic [31:0]   count_nxt;

  always_comb begin
    tick      = (presc == PW'(COUNT_DIV - 1));
    count_nxt = count;
    if (cnt_wen)
      count_nxt = wdata;
    else if (tick)
      count_nxt = count + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      presc <= (cnt_wen || tick) ? '0 : presc + PW'(1);
      count <= count_nxt;
      if (cmp_wen)
        compare <= wdata;
      // a Compare write clears TI even when Count reaches Compare on the same edge
      if (cmp_wen)
        ti <= 1'b0;
      else if (count_nxt != count && count_nxt == compare)
        ti <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_regfile_tlb.sv
// CP0 register file with TLB management registers, exception/interrupt state and timer.
// Define CP0_CONFIG_EN to expose read-only Config/Config1 at {16,0}/{16,1}.
module cp0_regfile_tlb
  import cp0_pkg::*;
#(
  parameter  int unsigned TLBNUM    = 16,
  parameter  int unsigned COUNT_DIV = 2,
  localparam int unsigned IW        = $clog2(TLBNUM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             cp0_addr,
  output logic [31:0]            cp0_rdata,
  input  logic                   cp0_wen,
  input  logic [31:0]            cp0_wdata,
  input  logic                   exc_valid,
  input  logic [4:0]             exc_code,
  input  logic [31:0]            exc_pc,
  input  logic                   exc_bd,
  input  logic [31:0]            exc_badvaddr,
  input  logic                   eret,
  input  logic [5:0]             hw_int,
  output logic                   int_req,
  output logic [31:0]            epc,
  input  logic                   tlbp_wen,
  input  logic                   tlbp_hit,
  input  logic [IW-1:0]          tlbp_idx,
  input  logic                   tlbr_wen,
  input  logic [TLB_ENTRY_W-1:0] tlbr_entry,
  output logic [31:0]            entryhi,
  output logic [IW-1:0]          tlb_index,
  output logic [IW-1:0]          tlb_random,
  output logic [TLB_ENTRY_W-1:0] tlbw_entry
);

  localparam logic [IW-1:0] RAND_TOP = IW'(TLBNUM - 1);

  logic                idx_p;
  logic [IW-1:0]       idx_q, random_q, wired_q;
  logic [TLB_LO_W:0]   lo0_q, lo1_q;
  logic [8:0]          ctx_base;
  logic [18:0]         ctx_vpn2;
  logic [18:0]         ehi_vpn2;
  logic [7:0]          ehi_asid;
  logic [31:0]         badvaddr_q, epc_q;
  logic [7:0]          im;
  logic                exl, ie;
  logic                cause_bd;
  logic [4:0]          exccode;
  logic [7:0]          ip;
  logic [31:0]         count, compare;
  logic                ti;

  logic wr_index, wr_lo0, wr_lo1, wr_context, wr_wired, wr_entryhi;
  logic wr_status, wr_cause, wr_epc, wr_count, wr_compare;
  logic exc_tlb, exc_bva;

  always_comb begin
    wr_index   = cp0_wen && cp0_addr == {REG_INDEX,    3'd0};
    wr_lo0     = cp0_wen && cp0_addr == {REG_ENTRYLO0, 3'd0};
    wr_lo1     = cp0_wen && cp0_addr == {REG_ENTRYLO1, 3'd0};
    wr_context = cp0_wen && cp0_addr == {REG_CONTEXT,  3'd0};
    wr_wired   = cp0_wen && cp0_addr == {REG_WIRED,    3'd0};
    wr_entryhi = cp0_wen && cp0_addr == {REG_ENTRYHI,  3'd0};
    wr_status  = cp0_wen && cp0_addr == {REG_STATUS,   3'd0};
    wr_cause   = cp0_wen && cp0_addr == {REG_CAUSE,    3'd0};
    wr_epc     = cp0_wen && cp0_addr == {REG_EPC,      3'd0};
    wr_count   = cp0_wen && cp0_addr == {REG_COUNT,    3'd0};
    wr_compare = cp0_wen && cp0_addr == {REG_COMPARE,  3'd0};
    exc_tlb    = exc_valid && (exc_code inside {EXC_MOD, EXC_TLBL, EXC_TLBS});
    exc_bva    = exc_tlb || (exc_valid && (exc_code inside {EXC_ADEL, EXC_ADES}));
  end

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .cnt_wen (wr_count),
    .cmp_wen (wr_compare),
    .wdata   (cp0_wdata),
    .count   (count),
    .compare (compare),
    .ti      (ti)
  );

  // Each register takes at most one source per edge; the if/else order encodes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_p      <= 1'b0;
      idx_q      <= '0;
      random_q   <= RAND_TOP;
      wired_q    <= '0;
      lo0_q      <= '0;
      lo1_q      <= '0;
      ctx_base   <= '0;
      ctx_vpn2   <= '0;
      ehi_vpn2   <= '0;
      ehi_asid   <= '0;
      badvaddr_q <= '0;
      epc_q      <= '0;
      im         <= '0;
      exl        <= 1'b0;
      ie         <= 1'b0;
      cause_bd   <= 1'b0;
      exccode    <= '0;
      ip         <= '0;
    end else begin
      if (tlbp_wen) begin
        idx_p <= ~tlbp_hit;
        idx_q <= tlbp_hit ? tlbp_idx : '0;
      end else if (wr_index)
        idx_q <= cp0_wdata[IW-1:0];

      if (wr_wired || random_q <= wired_q)
        random_q <= RAND_TOP;
      else
        random_q <= random_q - IW'(1);
      if (wr_wired)
        wired_q <= cp0_wdata[IW-1:0];

      if (exc_tlb)
        ehi_vpn2 <= exc_badvaddr[31:13];
      else if (tlbr_wen) begin
        ehi_vpn2 <= tlbr_entry[TLB_VPN2_LSB +: TLB_VPN2_W];
        ehi_asid <= tlbr_entry[TLB_ASID_LSB +: TLB_ASID_W];
      end else if (wr_entryhi) begin
        ehi_vpn2 <= cp0_wdata[31:13];
        ehi_asid <= cp0_wdata[7:0];
      end

      if (tlbr_wen) begin
        lo0_q <= {tlbr_entry[TLB_V0_LSB +: TLB_LO_W], tlbr_entry[TLB_G_LSB]};
        lo1_q <= {tlbr_entry[TLB_V1_LSB +: TLB_LO_W], tlbr_entry[TLB_G_LSB]};
      end else begin
        if (wr_lo0) lo0_q <= cp0_wdata[TLB_LO_W:0];
        if (wr_lo1) lo1_q <= cp0_wdata[TLB_LO_W:0];
      end

      if (exc_tlb)
        ctx_vpn2 <= exc_badvaddr[31:13];
      else if (wr_context)
        ctx_base <= cp0_wdata[31:23];

      if (exc_bva)
        badvaddr_q <= exc_badvaddr;

      if (exc_valid)
        exl <= 1'b1;
      else if (eret)
        exl <= 1'b0;
      else if (wr_status) begin
        im  <= cp0_wdata[15:8];
        exl <= cp0_wdata[1];
        ie  <= cp0_wdata[0];
      end

      ip[7:2] <= {hw_int[5] | ti, hw_int[4:0]};
      if (exc_valid) begin
        exccode <= exc_code;
        if (!exl)
          cause_bd <= exc_bd;
      end else if (wr_cause)
        ip[1:0] <= cp0_wdata[9:8];

      if (exc_valid) begin
        if (!exl)
          epc_q <= exc_bd ? exc_pc - 32'd4 : exc_pc;
      end else if (wr_epc)
        epc_q <= cp0_wdata;
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      {REG_INDEX,    3'd0}: cp0_rdata = {idx_p, {(31-IW){1'b0}}, idx_q};
      {REG_RANDOM,   3'd0}: cp0_rdata = {{(32-IW){1'b0}}, random_q};
      {REG_ENTRYLO0, 3'd0}: cp0_rdata = {{(31-TLB_LO_W){1'b0}}, lo0_q};
      {REG_ENTRYLO1, 3'd0}: cp0_rdata = {{(31-TLB_LO_W){1'b0}}, lo1_q};
      {REG_CONTEXT,  3'd0}: cp0_rdata = {ctx_base, ctx_vpn2, 4'b0};
      {REG_WIRED,    3'd0}: cp0_rdata = {{(32-IW){1'b0}}, wired_q};
      {REG_BADVADDR, 3'd0}: cp0_rdata = badvaddr_q;
      {REG_COUNT,    3'd0}: cp0_rdata = count;
      {REG_ENTRYHI,  3'd0}: cp0_rdata = {ehi_vpn2, 5'b0, ehi_asid};
      {REG_COMPARE,  3'd0}: cp0_rdata = compare;
      {REG_STATUS,   3'd0}: cp0_rdata = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
      {REG_CAUSE,    3'd0}: cp0_rdata = {cause_bd, ti, 14'b0, ip, 1'b0, exccode, 2'b0};
      {REG_EPC,      3'd0}: cp0_rdata = epc_q;
`ifdef CP0_CONFIG_EN
      {REG_CONFIG,   3'd0}: cp0_rdata = 32'h8000_0003;
      {REG_CONFIG,   3'd1}: cp0_rdata = {1'b0, 6'(TLBNUM - 1), 25'h0};
`endif
      default:              cp0_rdata = '0;
    endcase
  end

  assign int_req    = !exl && ie && |(im & ip);
  assign epc        = epc_q;
  assign entryhi    = {ehi_vpn2, 5'b0, ehi_asid};
  assign tlb_index  = idx_q;
  assign tlb_random = random_q;
  assign tlbw_entry = {ehi_vpn2, ehi_asid, lo0_q[0] & lo1_q[0],
                       lo0_q[TLB_LO_W:1], lo1_q[TLB_LO_W:1]};

endmodule

// File: tb/tb_cp0_regfile_tlb.sv
// Self-checking bench for cp0_regfile_tlb (TLBNUM=16, COUNT_DIV=2), randomized against a register-level model.
module tb_cp0_regfile_tlb;

  localparam int unsigned NTLB = 16;
  localparam int unsigned CDIV = 2;
  localparam int unsigned IW   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_rdata;
  logic        cp0_wen;
  logic [31:0] cp0_wdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [5:0]  hw_int;
  logic        int_req;
  logic [31:0] epc;
  logic        tlbp_wen;
  logic        tlbp_hit;
  logic [IW-1:0] tlbp_idx;
  logic        tlbr_wen;
  logic [77:0] tlbr_entry;
  logic [31:0] entryhi;
  logic [IW-1:0] tlb_index;
  logic [IW-1:0] tlb_random;
  logic [77:0] tlbw_entry;

  int total = 0;
  int bad   = 0;

  cp0_regfile_tlb #(.TLBNUM(NTLB), .COUNT_DIV(CDIV)) dut (
    .clk(clk), .rst(rst), .cp0_addr(cp0_addr), .cp0_rdata(cp0_rdata),
    .cp0_wen(cp0_wen), .cp0_wdata(cp0_wdata), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr), .eret(eret), .hw_int(hw_int),
    .int_req(int_req), .epc(epc), .tlbp_wen(tlbp_wen), .tlbp_hit(tlbp_hit),
    .tlbp_idx(tlbp_idx), .tlbr_wen(tlbr_wen), .tlbr_entry(tlbr_entry),
    .entryhi(entryhi), .tlb_index(tlb_index), .tlb_random(tlb_random),
    .tlbw_entry(tlbw_entry)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    cp0_addr = '0; cp0_wen = 1'b0; cp0_wdata = '0;
    exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0; exc_badvaddr = '0;
    eret = 1'b0; hw_int = '0;
    tlbp_wen = 1'b0; tlbp_hit = 1'b0; tlbp_idx = '0;
    tlbr_wen = 1'b0; tlbr_entry = '0;
  endtask

  // leaves the bench at a falling edge with reset released and all state at reset values
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rd(input int r, input int s, output logic [31:0] v);
    cp0_addr = {5'(r), 3'(s)};
    #1;
    v = cp0_rdata;
  endtask

  task automatic mtc0(input int r, input int s, input logic [31:0] d);
    cp0_addr  = {5'(r), 3'(s)};
    cp0_wdata = d;
    cp0_wen   = 1'b1;
    @(negedge clk);
    cp0_wen   = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    rd(1, 0, v);
    total++; if (v !== 32'h0000_000F) begin bad++; $display("FAIL reset_random: got %h expected %h", v, 32'h0000_000F); end
    rd(12, 0, v);
    total++; if (v !== 32'h0040_0000) begin bad++; $display("FAIL reset_status: got %h expected %h", v, 32'h0040_0000); end
    rd(0, 0, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_index: got %h expected 0", v); end
    total++; if ({int_req, epc, tlb_index, tlb_random} !== {1'b0, 32'h0, 4'h0, 4'hF}) begin
      bad++; $display("FAIL reset_ports: got int_req=%b epc=%h idx=%h rnd=%h expected 0/0/0/f", int_req, epc, tlb_index, tlb_random);
    end
  endtask

  task automatic test_random_seq();
    logic [31:0] v;
    int exp;
    do_reset();
    for (int k = 0; k < 34; k++) begin
      exp = (NTLB - 1) - (k % NTLB);
      rd(1, 0, v);
      total++; if (v !== 32'(exp) || tlb_random !== IW'(exp)) begin
        bad++; $display("FAIL random_seq[%0d]: got %h/%h expected %h", k, v, tlb_random, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wired();
    logic [31:0] v;
    int exp, w;
    do_reset();
    w = 4;
    mtc0(6, 0, 32'(w));
    for (int k = 0; k < 30; k++) begin
      exp = (NTLB - 1) - (k % (NTLB - w));
      rd(1, 0, v);
      total++; if (v !== 32'(exp)) begin bad++; $display("FAIL wired4_random[%0d]: got %h expected %h", k, v, exp); end
      @(negedge clk);
    end
    mtc0(6, 0, 32'hFFFF_FFFF);
    rd(6, 0, v);
    total++; if (v !== 32'h0000_000F) begin bad++; $display("FAIL wired_mask: got %h expected %h", v, 32'hF); end
    for (int k = 0; k < 6; k++) begin
      rd(1, 0, v);
      total++; if (v !== 32'h0000_000F) begin bad++; $display("FAIL wired15_random[%0d]: got %h expected f", k, v); end
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] wmask(input int r);
    case (r)
      0:       return 32'h0000_000F;
      2, 3:    return 32'h03FF_FFFF;
      4:       return 32'hFF80_0000;
      6:       return 32'h0000_000F;
      10:      return 32'hFFFF_E0FF;
      12:      return 32'h0000_FF03;
      14:      return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  task automatic test_mtc0_rand();
    logic [31:0] mdl [32];
    int regs [10] = '{0, 2, 3, 4, 5, 6, 8, 10, 12, 14};
    int r, s, r2, u;
    logic [31:0] d, v, exp;
    do_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    for (int i = 0; i < 60; i++) begin
      r = regs[$urandom_range(0, 9)];
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      d = $urandom;
      mtc0(r, s, d);
      if (s == 0) mdl[r] = (mdl[r] & ~wmask(r)) | (d & wmask(r));
      r2 = regs[$urandom_range(0, 9)];
      rd(r2, 0, v);
      exp = mdl[r2] | ((r2 == 12) ? 32'h0040_0000 : 32'h0);
      total++; if (v !== exp) begin bad++; $display("FAIL mtc0_rand reg%0d: got %h expected %h", r2, v, exp); end
      u = $urandom_range(0, 15);
      u = (u == 0) ? 7 : (u == 1) ? 15 : 16 + u;
      rd(u, 0, v);
      total++; if (v !== 32'h0) begin bad++; $display("FAIL unmapped reg%0d: got %h expected 0", u, v); end
    end
  endtask

  task automatic test_exception();
    logic [31:0] v, bva;
    bva = 32'h1234_5678;
    do_reset();
    mtc0(10, 0, 32'h0000_00A5);
    exc_valid = 1'b1; exc_code = 5'd2; exc_pc = 32'hBFC0_0100; exc_bd = 1'b1; exc_badvaddr = bva;
    @(negedge clk);
    exc_valid = 1'b0;
    rd(14, 0, v);
    total++; if (v !== 32'hBFC0_00FC || epc !== 32'hBFC0_00FC) begin bad++; $display("FAIL exc_epc: got %h/%h expected bfc000fc", v, epc); end
    rd(13, 0, v);
    total++; if (v !== 32'h8000_0008) begin bad++; $display("FAIL exc_cause: got %h expected 80000008", v); end
    rd(8, 0, v);
    total++; if (v !== bva) begin bad++; $display("FAIL exc_badvaddr: got %h expected %h", v, bva); end
    rd(4, 0, v);
    total++; if (v !== ((bva >> 13) << 4)) begin bad++; $display("FAIL exc_context: got %h expected %h", v, (bva >> 13) << 4); end
    rd(10, 0, v);
    total++; if (v !== ((bva & 32'hFFFF_E000) | 32'hA5) || entryhi !== v) begin bad++; $display("FAIL exc_entryhi: got %h expected %h", v, (bva & 32'hFFFF_E000) | 32'hA5); end
    @(negedge clk);
    exc_valid = 1'b1; exc_code = 5'd12; exc_pc = 32'h0000_1000; exc_bd = 1'b0; exc_badvaddr = 32'hFFFF_FFFF;
    @(negedge clk);
    exc_valid = 1'b0;
    rd(14, 0, v);
    total++; if (v !== 32'hBFC0_00FC) begin bad++; $display("FAIL exc2_epc_held: got %h expected bfc000fc", v); end
    rd(13, 0, v);
    total++; if (v !== 32'h8000_0030) begin bad++; $display("FAIL exc2_cause: got %h expected 80000030", v); end
    rd(8, 0, v);
    total++; if (v !== bva) begin bad++; $display("FAIL exc2_badvaddr_held: got %h expected %h", v, bva); end
    rd(12, 0, v);
    total++; if (v !== 32'h0040_0002) begin bad++; $display("FAIL exc_status_exl: got %h expected 00400002", v); end
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
    rd(12, 0, v);
    total++; if (v !== 32'h0040_0000) begin bad++; $display("FAIL eret_status: got %h expected 00400000", v); end
  endtask

  task automatic test_timer();
    logic [31:0] v, vc;
    int c;
    do_reset();
    c = $urandom_range(3, 8);
    mtc0(12, 0, 32'h0000_8001);
    mtc0(11, 0, 32'(c));
    mtc0(9, 0, 32'h0);
    for (int k = 0; k <= 2 * c + 2; k++) begin
      rd(13, 0, v);
      total++; if (v[30] !== (k >= c * CDIV)) begin bad++; $display("FAIL timer_ti[%0d]: got %b expected %b", k, v[30], k >= c * CDIV); end
      rd(9, 0, vc);
      total++; if (vc !== 32'(k / CDIV)) begin bad++; $display("FAIL timer_count[%0d]: got %h expected %h", k, vc, k / CDIV); end
      total++; if (int_req !== (k >= c * CDIV + 1)) begin bad++; $display("FAIL timer_int_req[%0d]: got %b expected %b", k, int_req, k >= c * CDIV + 1); end
      @(negedge clk);
    end
    mtc0(11, 0, 32'(c));
    rd(13, 0, v);
    total++; if (v[30] !== 1'b0) begin bad++; $display("FAIL timer_ti_clear: got %b expected 0", v[30]); end
    @(negedge clk);
    rd(13, 0, v);
    total++; if (int_req !== 1'b0 || v[15] !== 1'b0) begin bad++; $display("FAIL timer_int_clear: got %b/%b expected 0/0", int_req, v[15]); end
  endtask

  task automatic test_hw_int();
    logic [31:0] v;
    logic [5:0] h;
    do_reset();
    h = 6'($urandom_range(1, 31));
    mtc0(12, 0, 32'h0000_FF01);
    hw_int = h;
    #1;
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL hw_int_latency: got %b expected 0", int_req); end
    @(negedge clk);
    rd(13, 0, v);
    total++; if (v[15:10] !== h || int_req !== 1'b1) begin bad++; $display("FAIL hw_int_ip: got %h/%b expected %h/1", v[15:10], int_req, h); end
    exc_valid = 1'b1; exc_code = 5'd0;
    @(negedge clk);
    exc_valid = 1'b0;
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL hw_int_exl_mask: got %b expected 0", int_req); end
    hw_int = '0;
  endtask

  task automatic test_tlb();
    logic [31:0] v, exp;
    logic [18:0] vpn2; logic [7:0] asid; logic g;
    logic [19:0] pfn0, pfn1; logic [2:0] c0, c1; logic d0, v0, d1, v1;
    logic [77:0] ent;
    do_reset();
    tlbp_wen = 1'b1; tlbp_hit = 1'b0; tlbp_idx = 4'($urandom);
    @(negedge clk);
    tlbp_wen = 1'b0;
    rd(0, 0, v);
    total++; if (v !== 32'h8000_0000) begin bad++; $display("FAIL tlbp_miss: got %h expected 80000000", v); end
    mtc0(0, 0, 32'hFFFF_FFFF);
    rd(0, 0, v);
    total++; if (v !== 32'h8000_000F) begin bad++; $display("FAIL index_p_kept: got %h expected 8000000f", v); end
    tlbp_wen = 1'b1; tlbp_hit = 1'b1; tlbp_idx = 4'd3;
    @(negedge clk);
    tlbp_wen = 1'b0;
    rd(0, 0, v);
    total++; if (v !== 32'h0000_0003 || tlb_index !== 4'd3) begin bad++; $display("FAIL tlbp_hit: got %h/%h expected 3", v, tlb_index); end
    tlbr_wen = 1'b1; tlbr_entry = '1;
    @(negedge clk);
    tlbr_wen = 1'b0;
    rd(10, 0, v);
    total++; if (v !== 32'hFFFF_E0FF) begin bad++; $display("FAIL tlbr_ones_ehi: got %h expected ffffe0ff", v); end
    rd(2, 0, v);
    total++; if (v !== 32'h03FF_FFFF) begin bad++; $display("FAIL tlbr_ones_lo0: got %h expected 03ffffff", v); end
    total++; if (tlbw_entry !== {78{1'b1}}) begin bad++; $display("FAIL tlbw_ones: got %h expected all ones", tlbw_entry); end
    for (int i = 0; i < 8; i++) begin
      vpn2 = 19'($urandom); asid = 8'($urandom); g = 1'($urandom);
      pfn0 = 20'($urandom); c0 = 3'($urandom); d0 = 1'($urandom); v0 = 1'($urandom);
      pfn1 = 20'($urandom); c1 = 3'($urandom); d1 = 1'($urandom); v1 = 1'($urandom);
      ent = {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
      tlbr_wen = 1'b1; tlbr_entry = ent;
      @(negedge clk);
      tlbr_wen = 1'b0;
      rd(10, 0, v); exp = {vpn2, 5'b0, asid};
      total++; if (v !== exp || entryhi !== exp) begin bad++; $display("FAIL tlbr_ehi[%0d]: got %h expected %h", i, v, exp); end
      rd(2, 0, v); exp = {6'b0, pfn0, c0, d0, v0, g};
      total++; if (v !== exp) begin bad++; $display("FAIL tlbr_lo0[%0d]: got %h expected %h", i, v, exp); end
      rd(3, 0, v); exp = {6'b0, pfn1, c1, d1, v1, g};
      total++; if (v !== exp) begin bad++; $display("FAIL tlbr_lo1[%0d]: got %h expected %h", i, v, exp); end
      total++; if (tlbw_entry !== ent) begin bad++; $display("FAIL tlbw_roundtrip[%0d]: got %h expected %h", i, tlbw_entry, ent); end
    end
    mtc0(2, 0, 32'h0000_0000);
    mtc0(3, 0, 32'h0000_0001);
    total++; if (tlbw_entry[50] !== 1'b0) begin bad++; $display("FAIL tlbw_g_and: got %b expected 0", tlbw_entry[50]); end
  endtask

  task automatic test_priority();
    logic [31:0] v;
    do_reset();
    exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h0000_0400; exc_bd = 1'b0; exc_badvaddr = 32'hDEAD_BEEF;
    cp0_addr = {5'd14, 3'd0}; cp0_wdata = 32'h0000_1234; cp0_wen = 1'b1;
    @(negedge clk);
    exc_valid = 1'b0; cp0_wen = 1'b0;
    rd(14, 0, v);
    total++; if (v !== 32'h0000_0400) begin bad++; $display("FAIL prio_exc_epc: got %h expected 00000400", v); end
    rd(8, 0, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL prio_sys_badvaddr: got %h expected 0", v); end
    eret = 1'b1;
    cp0_addr = {5'd12, 3'd0}; cp0_wdata = 32'h0000_FF03; cp0_wen = 1'b1;
    @(negedge clk);
    eret = 1'b0; cp0_wen = 1'b0;
    rd(12, 0, v);
    total++; if (v !== 32'h0040_0000) begin bad++; $display("FAIL prio_eret_status: got %h expected 00400000", v); end
    tlbr_wen = 1'b1; tlbr_entry = '0;
    cp0_addr = {5'd10, 3'd0}; cp0_wdata = 32'hFFFF_FFFF; cp0_wen = 1'b1;
    @(negedge clk);
    tlbr_wen = 1'b0; cp0_wen = 1'b0;
    rd(10, 0, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL prio_tlbr_entryhi: got %h expected 0", v); end
  endtask

  task automatic test_config();
    logic [31:0] v, e0, e1;
`ifdef CP0_CONFIG_EN
    e0 = 32'h8000_0003;
    e1 = 32'(NTLB - 1) << 25;
`else
    e0 = 32'h0;
    e1 = 32'h0;
`endif
    do_reset();
    mtc0(16, 0, 32'hFFFF_FFFF);
    mtc0(16, 1, 32'hFFFF_FFFF);
    rd(16, 0, v);
    total++; if (v !== e0) begin bad++; $display("FAIL config0: got %h expected %h", v, e0); end
    rd(16, 1, v);
    total++; if (v !== e1) begin bad++; $display("FAIL config1: got %h expected %h", v, e1); end
    rd(12, 1, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL status_sel1: got %h expected 0", v); end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_random_seq();
    test_wired();
    test_mtc0_rand();
    test_exception();
    test_timer();
    test_hw_int();
    test_tlb();
    test_priority();
    test_config();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_regfile_tlb.md
Name: cp0_regfile_tlb

Overview:
Parametrised next-generation CP0 register file for the MIPS pipeline, instanced beside the WB stage.
- Holds exception, interrupt and timer state plus the full TLB-management register set: Index, Random, Wired, EntryLo0/1, Context, PageMask and EntryHi.
- Provides tlbp/tlbr/tlbwi/tlbwr plumbing, TLB-refill exception side effects and a divided timer with configurable division.

Parameters:
TLBNUM, 16, TLB entry count (power of two, 2..64); IW = clog2(TLBNUM)
COUNT_DIV, 2, clk cycles per Count increment (power of two, >=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cp0_addr  in  8  {regnum[4:0], sel[2:0]}
cp0_rdata  out  32  combinational read data
cp0_wen  in  1  mtc0 write strobe
cp0_wdata  in  32  mtc0 data
exc_valid  in  1  exception commit strobe
exc_code  in  5  resolved ExcCode
exc_pc  in  32  faulting PC
exc_bd  in  1  faulting instruction is in a delay slot
exc_badvaddr  in  32  faulting virtual address
eret  in  1  eret commit
hw_int  in  6  external interrupt lines
int_req  out  1  interrupt pending and enabled
epc  out  32  EPC value
tlbp_wen  in  1  tlbp result strobe
tlbp_hit  in  1  tlbp hit
tlbp_idx  in  IW  tlbp hit index
tlbr_wen  in  1  tlbr result strobe
tlbr_entry  in  78  {VPN2[19],ASID[8],G,PFN0[20],C0[3],D0,V0,PFN1[20],C1[3],D1,V1}
entryhi  out  32  EntryHi for tlbp/fetch ASID
tlb_index  out  IW  Index[IW-1:0] for tlbr/tlbwi
tlb_random  out  IW  Random for tlbwr
tlbw_entry  out  78  entry built from EntryHi/Lo0/Lo1, same layout; G = Lo0.G & Lo1.G

Behaviour:
- Register map {regnum,sel}:
  - Index 0, Random 1, EntryLo0 2, EntryLo1 3, Context 4, PageMask 5 (reads 0), Wired 6.
  - BadVAddr 8, Count 9, EntryHi 10, Compare 11, Status 12, Cause 13, EPC 14.
  - Unmapped regnum or sel!=0 (except under the optional feature): read 0, write ignored.
- Write masks:
  - Index[IW-1:0]; Index.P[31] is written only by tlbp.
  - EntryLo*[25:0].
  - Context[31:23].
  - Wired[IW-1:0].
  - EntryHi[31:13] and [7:0].
  - Status IM[15:8], EXL[1], IE[0]; BEV[22] reads 1.
  - Cause IP[9:8].
  - Compare and Count: full 32 bits.
- Reset values:
  - All registers 0, except Random = TLBNUM-1 and BEV = 1.
  - Outputs at reset: int_req=0, epc=0, tlb_index=0, tlb_random=TLBNUM-1.
- Exception (exc_valid):
  - Cause.ExcCode <= exc_code.
  - EXL <= 1.
  - If the old EXL is 0: EPC <= exc_bd ? exc_pc-4 : exc_pc, and Cause.BD <= exc_bd. If the old EXL is 1, EPC and BD are held.
  - exc_code in {1,2,3,4,5} loads BadVAddr.
  - exc_code in {1,2,3} also loads Context[22:4] <= exc_badvaddr[31:13] and EntryHi[31:13] <= exc_badvaddr[31:13]; ASID is unchanged.
- eret: EXL <= 0.
- Priority: rst > exc_valid > eret > tlbp/tlbr > mtc0. When a higher-priority event touches a register, a same-cycle mtc0 to it is dropped.
- tlbp_wen: Index <= {~tlbp_hit, 0.., tlbp_idx}. On miss the low bits are undefined; the block writes 0.
- tlbr_wen: EntryHi <= {VPN2, 5'b0, ASID}; EntryLoN <= {6'b0, PFNN, CN, DN, VN, G}.
- Random:
  - Decrements every cycle.
  - When Random <= Wired, the next value is TLBNUM-1.
  - An mtc0 to Wired forces Random = TLBNUM-1 on the following edge.
  - If Wired = TLBNUM-1, Random stays at TLBNUM-1.
- Timer:
  - Prescaler counts 0..COUNT_DIV-1; Count += 1 when it wraps; Count wraps 0xFFFFFFFF->0.
  - An mtc0 to Count loads it and clears the prescaler.
  - Cause.TI sets on the edge where Count becomes equal to Compare.
  - An mtc0 to Compare clears TI; if both happen the same cycle, the clear wins.
- Cause.IP[7:2]: registered each cycle from {hw_int[5]|TI, hw_int[4:0]}, one-cycle latency.
- int_req (combinational): !EXL & IE & |(IM & IP).

Optional Feature:
Macro CP0_CONFIG_EN.
- Defined: read-only Config {16,0} and Config1 {16,1}.
  - Config = 0x80000003 (M=1, K0=3).
  - Config1 = {1'b0, (TLBNUM-1) in [30:25], 25'h0}.
- Undefined: both read 0; writes are ignored in both cases.

Decomposition:
- Package cp0_pkg holds:
  - Register-number localparams.
  - ExcCode constants: INT 0, MOD 1, TLBL 2, TLBS 3, ADEL 4, ADES 5, SYS 8, BP 9, RI 10, OV 12.
  - TLB entry field offsets/widths (78-bit layout).
- Sub-module cp0_timer holds Count, prescaler, Compare and TI, with ports cnt_wen, cmp_wen, wdata, count, compare, ti.

Test Plan:
- Reset, then read Random, Status and Index:
  - Random=TLBNUM-1 (0xF), Status=0x00400000, Index=0.
  - Random steps 0xF->0xE->...->0x0->0xF.
- mtc0 Wired=4:
  - Random reads 0xF the next cycle and cycles 0xF..0x4 only.
  - Wired=0xF holds Random at 0xF.
- exc_valid with code 2, badvaddr 0x12345678, exc_pc 0xBFC00100, bd=1, EXL=0:
  - EPC=0xBFC000FC, Cause=0x80000008, BadVAddr=0x12345678, Context[22:4]=0x091A2, EntryHi[31:13]=0x091A2.
  - A second exception with EXL=1 leaves EPC unchanged.
- COUNT_DIV=2, Compare=5, Count=0:
  - TI sets after 10 cycles and int_req=1 with IM7=1, IE=1.
  - mtc0 Compare clears TI and int_req.
- tlbp miss, then hit index 3:
  - Miss: Index=0x80000000. Hit: Index=0x00000003.
  - tlbr_entry with all fields set reads back masked; tlbw_entry round-trips it.
- Same-cycle exc_valid and mtc0 EPC=0x1234: the exception value is kept.
- CP0_CONFIG_EN defined: Config1[30:25]=0xF. Undefined: reads 0.
